decoder_seq: RTL and testbench

//  Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder. Successor to the 2-to-4 dataflow decoder.

---
 rtl/decoder_seq.sv | 100 ++++++++++
 tb/tb_decoder_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with DIRECT (handshake) and SCAN (dwell-timed walk) modes.
// Optional code parity checking is compiled in when DECODER_PARITY_EN is defined.
module decoder_seq #(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 8,
   localparam int OUT_W  = 1 << SEL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SEL_W-1:0]   code,
   input  logic [DWELL_W-1:0] dwell,
   output logic [OUT_W-1:0]   y,
   output logic               out_valid,
   output logic [SEL_W-1:0]   idx,
   output logic               wrap
`ifdef DECODER_PARITY_EN
   ,
   input  logic               code_par,
   output logic               par_err
`endif
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DIRECT = 2'd1;
   localparam logic [1:0] ST_SCAN   = 2'd2;

   localparam logic [OUT_W-1:0] LINE0 = {{(OUT_W-1){1'b0}}, 1'b1};

   logic [1:0]         state;
   logic [DWELL_W-1:0] cnt;
   logic               xfer;
   logic               code_ok;

   assign in_ready = (state == ST_DIRECT);
   assign xfer     = in_valid & in_ready;

`ifdef DECODER_PARITY_EN
   assign code_ok = ~(^{code, code_par});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_err <= 1'b0;
      else        par_err <= xfer & ~code_ok;
   end
`else
   assign code_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         y         <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
         cnt       <= '0;
      end else begin
         wrap <= 1'b0;
         if (!en || (state != ST_IDLE && state != ST_DIRECT && state != ST_SCAN)) begin
            state     <= ST_IDLE;
            y         <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
         end else if (mode && state != ST_SCAN) begin
            // Entering SCAN: start on line 0 with a freshly sampled dwell
            state     <= ST_SCAN;
            y         <= LINE0;
            idx       <= '0;
            out_valid <= 1'b1;
            cnt       <= dwell;
         end else if (!mode && state != ST_DIRECT) begin
            state     <= ST_DIRECT;
            y         <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
         end else if (state == ST_DIRECT) begin
            if (xfer && code_ok) begin
               y         <= LINE0 << code;
               idx       <= code;
               out_valid <= 1'b1;
            end
         end else begin
            // SCAN hold: count the dwell down, then step to the next line
            if (cnt == '0) begin
               idx  <= idx + 1'b1;
               y    <= {y[OUT_W-2:0], y[OUT_W-1]};
               cnt  <= dwell;
               wrap <= &idx;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_decoder_seq.sv
// Randomized self-checking bench for decoder_seq against a line/hold-count reference model.
// Parity checks are included when DECODER_PARITY_EN is defined.
module tb_decoder_seq;

   localparam int SEL_W   = 3;
   localparam int DWELL_W = 8;
   localparam int OUT_W   = 1 << SEL_W;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic               mode;
   logic               in_valid;
   logic               in_ready;
   logic [SEL_W-1:0]   code;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_W-1:0]   y;
   logic               out_valid;
   logic [SEL_W-1:0]   idx;
   logic               wrap;
`ifdef DECODER_PARITY_EN
   logic               code_par;
   logic               par_err;
   logic               bad_par;
   logic               m_par;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: 0 = idle, 1 = direct, 2 = scan
   int m_st;
   int m_idx;
   int m_hold;
   bit m_valid;
   bit m_wrap;
   int cyc;

   decoder_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .code      (code),
      .dwell     (dwell),
      .y         (y),
      .out_valid (out_valid),
      .idx       (idx),
      .wrap      (wrap)
`ifdef DECODER_PARITY_EN
      ,
      .code_par  (code_par),
      .par_err   (par_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_y();
      return m_valid ? (32'd1 << m_idx) : 32'd0;
   endfunction

   task automatic model_reset();
      m_st = 0; m_idx = 0; m_hold = 0; m_valid = 0; m_wrap = 0;
`ifdef DECODER_PARITY_EN
      m_par = 0;
`endif
   endtask

   task automatic model_edge();
      bit acc;
      bit good;
      acc  = in_valid && (m_st == 1);
      good = 1'b1;
`ifdef DECODER_PARITY_EN
      good  = ((code_par + $countones(code)) % 2) == 0;
      m_par = acc && !good;
`endif
      m_wrap = 0;
      if (!en) begin
         m_st = 0; m_valid = 0; m_idx = 0;
      end else if (m_st == 0 || (m_st == 1 && mode) || (m_st == 2 && !mode)) begin
         if (mode) begin
            m_st = 2; m_idx = 0; m_valid = 1; m_hold = int'(dwell) + 1;
         end else begin
            m_st = 1; m_valid = 0;
         end
      end else if (m_st == 1) begin
         if (acc && good) begin
            m_idx = int'(code); m_valid = 1;
         end
      end else begin
         m_hold--;
         if (m_hold == 0) begin
            m_idx  = (m_idx + 1) % OUT_W;
            m_hold = int'(dwell) + 1;
            m_wrap = (m_idx == 0);
         end
      end
   endtask

   task automatic compare_all();
      check("y", 32'(y), exp_y());
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(m_st == 1));
      check("wrap", 32'(wrap), 32'(m_wrap));
      if (m_valid || m_st == 0) check("idx", 32'(idx), 32'(m_idx));
`ifdef DECODER_PARITY_EN
      check("par_err", 32'(par_err), 32'(m_par));
`endif
   endtask

   task automatic drive(input logic e, input logic m, input logic v,
                        input logic [SEL_W-1:0] c, input logic [DWELL_W-1:0] d);
      en = e; mode = m; in_valid = v; code = c; dwell = d;
`ifdef DECODER_PARITY_EN
      code_par = (^c) ^ bad_par;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1 compare_all();
      @(negedge clk);
   endtask

   int wraps;
   int last_wrap;
   int guard;

   initial begin
      cyc = 0;
`ifdef DECODER_PARITY_EN
      bad_par = 1'b0;
`endif
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_y", 32'(y), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      step();
      check("first_ready", 32'(in_ready), 32'd1);

      // Back-to-back DIRECT codes, then hold with in_valid low
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, 1'b0, 1'b1, SEL_W'(c), '0);
         step();
         check("direct_y", 32'(y), 32'd1 << c);
      end
      drive(1'b1, 1'b0, 1'b0, 3'd1, '0);
      repeat (3) step();
      check("direct_hold", 32'(y), 32'h8);

      // SCAN with dwell=2: measure wrap spacing
      drive(1'b1, 1'b1, 1'b0, '0, 8'd2);
      wraps = 0; last_wrap = -1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (wrap) begin
            if (last_wrap >= 0) check("wrap_period", 32'(cyc - last_wrap), 32'd24);
            last_wrap = cyc;
            wraps++;
         end
      end
      check("wrap_count", 32'(wraps), 32'd2);

      // SCAN dwell=0, drop to DIRECT mid-scan, then decode code 2
      drive(1'b1, 1'b1, 1'b0, '0, 8'd0);
      repeat (5) step();
      drive(1'b1, 1'b0, 1'b1, 3'd5, 8'd0);
      step();
      check("to_direct_y", 32'(y), 32'd0);
      check("to_direct_valid", 32'(out_valid), 32'd0);
      drive(1'b1, 1'b0, 1'b1, 3'd2, 8'd0);
      step();
      check("code2_y", 32'(y), 32'h4);

      // Async reset mid-SCAN at idx=2
      drive(1'b1, 1'b1, 1'b0, '0, 8'd0);
      guard = 0;
      do begin
         step();
         guard++;
      end while (!(m_st == 2 && m_idx == 2) && guard < 20);
      check("reach_idx2", 32'(idx), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("midrst_y", 32'(y), 32'd0);
      check("midrst_idx", 32'(idx), 32'd0);
      check("midrst_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rescan_y", 32'(y), 32'h1);
      check("rescan_idx", 32'(idx), 32'd0);

`ifdef DECODER_PARITY_EN
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      step();
      bad_par = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 3'd1, '0);
      step();
      check("par_bad_err", 32'(par_err), 32'd1);
      bad_par = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 3'd1, '0);
      step();
      check("par_good_y", 32'(y), 32'h2);
      check("par_good_err", 32'(par_err), 32'd0);
`endif

      // Randomized traffic against the model
      begin
         logic m_r;
         m_r = 1'b0;
         for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 4) m_r = ~m_r;
`ifdef DECODER_PARITY_EN
            bad_par = ($urandom_range(0, 9) == 0);
`endif
            drive(($urandom_range(0, 99) >= 5), m_r, 1'($urandom),
                  SEL_W'($urandom), DWELL_W'($urandom_range(0, 3)));
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
